// File: rtl/seq_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer_pkg
// Description : Shared constants, state encoding and sizing helper for the
//               sequence-word serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_serializer_pkg;

    localparam int C_DEF_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer_if
// Description : Valid/ready word handshake feeding the serialiser FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_serializer_if
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
);

    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_word,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_word,
        input  in_valid,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/seq_serializer_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer_word_fifo
// Description : Synchronous word FIFO with push/pop, synchronous clear and an
//               occupancy count; pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer_word_fifo
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  wire                            clk,
    input  wire                            rst,
    input  wire                            clr,
    input  wire                            push,
    input  wire                            pop,
    input  wire  [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full blocks a push even when a pop lands in the same cycle.
    assign w_push = push && !clr && (r_count < CW'(DEPTH));
    assign w_pop  = pop  && !clr && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : Buffers sequence words and shifts them MSB-first onto a 1-bit
//               stream, each bit held HOLD cycles, with no gap between words.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input  wire                            clk,
    input  wire                            rst,    // asynchronous, active low
    input  wire                            clr,
    seq_serializer_if.slave                up,
    output logic                           x,
    output logic                           x_valid,
    output logic                           last_bit,
    output logic                           busy,
    output logic [count_width(DEPTH)-1:0]  fifo_count,
    output logic [15:0]                    words_done
);

    localparam int CW = count_width(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [BW-1:0] C_BIT_FIRST = BW'(WIDTH - 1);
    localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLD - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;
    logic [HW-1:0]    r_hold_cnt;
    logic [15:0]      r_words_done;
    logic             r_x;
    logic             r_x_valid;
    logic             r_last_bit;
    logic             r_busy;

    state_t           w_state;
    logic [WIDTH-1:0] w_shreg;
    logic [BW-1:0]    w_bit_cnt;
    logic [HW-1:0]    w_hold_cnt;
    logic [15:0]      w_words_done;
    logic             w_x;
    logic             w_x_valid;
    logic             w_last_bit;
    logic             w_busy;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_fifo_dout;
    logic [CW-1:0]    w_fifo_count;

    assign w_in_ready  = (w_fifo_count < CW'(DEPTH));
    assign w_push      = up.in_valid && w_in_ready;
    assign up.in_ready = w_in_ready;

    seq_serializer_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (up.in_word),
        .dout  (w_fifo_dout),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_words_done <= '0;
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_last_bit   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_shreg      <= w_shreg;
            r_bit_cnt    <= w_bit_cnt;
            r_hold_cnt   <= w_hold_cnt;
            r_words_done <= w_words_done;
            r_x          <= w_x;
            r_x_valid    <= w_x_valid;
            r_last_bit   <= w_last_bit;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_shreg      = r_shreg;
        w_bit_cnt    = r_bit_cnt;
        w_hold_cnt   = r_hold_cnt;
        w_words_done = r_words_done;
        w_pop        = 1'b0;

        if (clr) begin
            w_state    = ST_IDLE;
            w_shreg    = '0;
            w_bit_cnt  = '0;
            w_hold_cnt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fifo_count != '0) begin
                        w_pop      = 1'b1;
                        w_shreg    = w_fifo_dout;
                        w_bit_cnt  = C_BIT_FIRST;
                        w_hold_cnt = C_HOLD_LOAD;
                        w_state    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_hold_cnt != '0) begin
                        w_hold_cnt = r_hold_cnt - 1'b1;
                    end else if (r_bit_cnt != '0) begin
                        w_shreg    = {r_shreg[WIDTH-2:0], 1'b0};
                        w_bit_cnt  = r_bit_cnt - 1'b1;
                        w_hold_cnt = C_HOLD_LOAD;
                    end else begin
                        // Last cycle of the LSB: chain straight into the next word.
                        w_words_done = r_words_done + 16'd1;
                        if (w_fifo_count != '0) begin
                            w_pop      = 1'b1;
                            w_shreg    = w_fifo_dout;
                            w_bit_cnt  = C_BIT_FIRST;
                            w_hold_cnt = C_HOLD_LOAD;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end

        w_x_valid  = (w_state == ST_SHIFT);
        w_busy     = (w_state == ST_SHIFT);
        w_x        = (w_state == ST_SHIFT) && w_shreg[WIDTH-1];
        w_last_bit = (w_state == ST_SHIFT) && (w_bit_cnt == '0);
    end

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign last_bit   = r_last_bit;
    assign busy       = r_busy;
    assign fifo_count = w_fifo_count;
    assign words_done = r_words_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_serializer
// Description : Scoreboard bench driving two serialisers (HOLD=1 and HOLD=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;
    import seq_serializer_pkg::*;

    localparam int W    = 32;
    localparam int D    = 4;
    localparam int CW   = count_width(D);
    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [NDUT];
    logic          clr   [NDUT];
    logic [W-1:0]  word  [NDUT];
    logic          valid [NDUT];
    logic          ready [NDUT];
    logic          xo    [NDUT];
    logic          xv    [NDUT];
    logic          lb    [NDUT];
    logic          bz    [NDUT];
    logic [CW-1:0] cnt   [NDUT];
    logic [15:0]   done  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        seq_serializer_if #(.WIDTH(W)) bus ();
        assign bus.in_word  = word[g];
        assign bus.in_valid = valid[g];
        assign ready[g]     = bus.in_ready;
        seq_serializer #(.WIDTH(W), .DEPTH(D), .HOLD(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .clr        (clr[g]),
            .up         (bus),
            .x          (xo[g]),
            .x_valid    (xv[g]),
            .last_bit   (lb[g]),
            .busy       (bz[g]),
            .fifo_count (cnt[g]),
            .words_done (done[g])
        );
    end

    // Reference model: accepted words awaiting output, position in the head word.
    logic [W-1:0] q [NDUT][$];
    int  pos     [NDUT];
    int  n_push  [NDUT];
    int  n_start [NDUT];
    int  dmodel  [NDUT];
    bit  pend    [NDUT];
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic void chk(int k, string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %0h, expected %0h", k, name, act, exp);
        end
    endfunction

    function automatic void flush(int k, bit full_reset);
        q[k].delete();
        pos[k]     = 0;
        n_push[k]  = 0;
        n_start[k] = 0;
        pend[k]    = 1'b0;
        if (full_reset) dmodel[k] = 0;
    endfunction

    always @(negedge clk) begin : mon
        int h;
        int p;
        int occ;
        logic [W-1:0] w;
        for (int k = 0; k < NDUT; k++) begin
            h = k + 1;
            if (pend[k]) begin
                dmodel[k]++;
                pend[k] = 1'b0;
            end
            chk(k, "words_done", done[k], 64'(16'(dmodel[k])));
            if (q[k].size() == 0 || (pos[k] == 0 && xv[k] !== 1'b1)) begin
                chk(k, "x_valid_idle", xv[k], 0);
                chk(k, "x_idle", xo[k], 0);
                chk(k, "last_bit_idle", lb[k], 0);
                chk(k, "busy_idle", bz[k], 0);
            end else begin
                w = q[k][0];
                p = pos[k];
                if (p == 0) n_start[k]++;
                chk(k, "x_valid", xv[k], 1);
                chk(k, "x_bit", xo[k], w[W-1-(p/h)]);
                chk(k, "last_bit", lb[k], (p / h) == (W - 1));
                chk(k, "busy", bz[k], 1);
                pos[k]++;
                if (pos[k] == W * h) begin
                    void'(q[k].pop_front());
                    pos[k]  = 0;
                    pend[k] = 1'b1;
                end
            end
            occ = n_push[k] - n_start[k];
            chk(k, "fifo_count", cnt[k], occ);
            chk(k, "in_ready", ready[k], occ < D);
        end
    end

    task automatic send(int k, logic [W-1:0] w);
        bit acc;
        int t;
        word[k]  = w;
        valid[k] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            acc = ready[k];
            @(posedge clk);
            t++;
        end while (!acc && t < 500);
        chk(k, "push_accepted", acc, 1);
        if (acc) begin
            q[k].push_back(w);
            n_push[k]++;
        end
        #1;
        valid[k] = 1'b0;
        word[k]  = $urandom;
    endtask

    task automatic drain(int k);
        int t;
        t = 0;
        while (q[k].size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk(k, "drain_pending", q[k].size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(int k, int nbits);
        int t;
        t = 0;
        while (pos[k] < nbits * (k + 1) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(k, "reached_bit", pos[k] >= nbits * (k + 1), 1);
    endtask

    task automatic do_clr(int k, bit with_push);
        int kept;
        clr[k] = 1'b1;
        if (with_push) begin
            word[k]  = $urandom;
            valid[k] = 1'b1;
        end
        @(posedge clk);
        flush(k, 1'b0);
        kept = dmodel[k];
        #1;
        clr[k]   = 1'b0;
        valid[k] = 1'b0;
        chk(k, "clr_x_valid", xv[k], 0);
        chk(k, "clr_x", xo[k], 0);
        chk(k, "clr_count", cnt[k], 0);
        chk(k, "clr_words_done", done[k], 64'(16'(kept)));
    endtask

    task automatic suite(int k);
        int h;
        int run;
        h = k + 1;
        repeat (2) @(posedge clk);
        #1;
        chk(k, "rst_x", xo[k], 0);
        chk(k, "rst_x_valid", xv[k], 0);
        chk(k, "rst_last_bit", lb[k], 0);
        chk(k, "rst_busy", bz[k], 0);
        chk(k, "rst_count", cnt[k], 0);
        chk(k, "rst_words_done", done[k], 0);
        chk(k, "rst_in_ready", ready[k], 1);
        rst[k] = 1'b1;
        @(posedge clk);
        #1;

        send(k, 32'hAAAA_AAAA);
        chk(k, "latency_push_edge", xv[k], 0);
        @(posedge clk);
        #1;
        chk(k, "latency_next_edge", xv[k], 1);
        chk(k, "first_msb", xo[k], 1);
        drain(k);
        chk(k, "done_single", done[k], 1);

        send(k, 32'hAAAA_AAAA);
        send(k, 32'h2318_C631);
        run = 0;
        for (int t = 0; t < 400 && (run == 0 || xv[k]); t++) begin
            @(negedge clk);
            if (xv[k]) run++;
        end
        chk(k, "back_to_back_run", run, 2 * W * h);
        drain(k);
        chk(k, "done_b2b", done[k], 3);

        for (int i = 0; i < 6; i++) begin
            send(k, $urandom);
            if (i == 4) begin
                chk(k, "full_count", cnt[k], D);
                chk(k, "full_in_ready", ready[k], 0);
            end
        end
        drain(k);
        chk(k, "done_six", done[k], 9);

        send(k, 32'hA8A8_A0FC);
        drain(k);
        chk(k, "done_hold_word", done[k], 10);

        send(k, 32'h88AA_A2AA);
        send(k, $urandom);
        send(k, $urandom);
        wait_bit(k, 16);
        rst[k] = 1'b0;
        flush(k, 1'b1);
        #1;
        chk(k, "async_rst_x", xo[k], 0);
        chk(k, "async_rst_x_valid", xv[k], 0);
        chk(k, "async_rst_count", cnt[k], 0);
        chk(k, "async_rst_words_done", done[k], 0);
        @(posedge clk);
        #1;
        rst[k] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk(k, "post_rst_idle", xv[k], 0);

        for (int i = 0; i < 3; i++) send(k, $urandom);
        drain(k);
        chk(k, "done_before_clr", done[k], 3);
        send(k, 32'hFFFF_FFFF);
        send(k, $urandom);
        wait_bit(k, 10);
        do_clr(k, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk(k, "clr_push_ignored", cnt[k], 0);
        chk(k, "clr_stays_idle", xv[k], 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 19) == 0) do_clr(k, $urandom_range(0, 1) == 1);
            else send(k, $urandom);
        end
        drain(k);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst[k]   = 1'b0;
            clr[k]   = 1'b0;
            valid[k] = 1'b0;
            word[k]  = '0;
            flush(k, 1'b1);
        end
        suite(0);
        suite(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
